fibre_a_responder: RTL and testbench

FIBRE_A_RESPONDER -- requirements
Module: fibre_a_responder

---
 rtl/fibre_a_responder_if.sv | 27 ++
 rtl/fibre_a_responder.sv | 122 ++++++++++++
 tb/tb_fibre_a_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fibre_a_responder_if.sv
// Load-side write port and TPPE read port of the fibre_a responder.
// The master drives writes and read requests; the slave returns responses and status.
interface fibre_a_responder_if #(
  parameter int TIMESTEPS  = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [TIMESTEPS-1:0]  wr_data;
  logic [ADDR_WIDTH-1:0] fibre_a_addr;
  logic                  fibre_a_read_en;
  logic [TIMESTEPS-1:0]  fibre_a_data;
  logic                  fibre_a_valid;
  logic                  rd_miss;
  logic                  rd_oob;
  logic [15:0]           reads_served;

  modport master (
    output wr_en, wr_addr, wr_data, fibre_a_addr, fibre_a_read_en,
    input  fibre_a_data, fibre_a_valid, rd_miss, rd_oob, reads_served
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, fibre_a_addr, fibre_a_read_en,
    output fibre_a_data, fibre_a_valid, rd_miss, rd_oob, reads_served
  );
endinterface

// File: rtl/fibre_a_responder.sv
// Fibre_a spike-train store with a fixed-latency, non-stalling read pipeline.
// Reads sample the array (write-first) in the request cycle; unwritten or out-of-range entries return zero.
module fibre_a_responder #(
  parameter int TIMESTEPS    = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  fibre_a_responder_if.slave  bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  logic [TIMESTEPS-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]     r_written;
  logic                 r_miss;
  logic                 r_oob;
  logic [15:0]          r_served;

  logic                 w_wr_in_range;
  logic                 w_wr_ok;
  logic                 w_wr_oob;
  logic                 w_rd_oob;
  logic                 w_fwd;
  logic                 w_vld_p0;
  logic                 w_miss_p0;
  logic [TIMESTEPS-1:0] w_data_p0;
  logic                 w_out_vld;

  assign w_wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_LIM);
  assign w_wr_ok       = !rst && bus.wr_en && w_wr_in_range;
  assign w_wr_oob      = !rst && bus.wr_en && !w_wr_in_range;
  assign w_vld_p0      = !rst && bus.fibre_a_read_en;
  assign w_rd_oob      = w_vld_p0 && ({1'b0, bus.fibre_a_addr} >= DEPTH_LIM);
  assign w_fwd         = w_wr_ok && (bus.wr_addr == bus.fibre_a_addr);

  // Request stage: resolve the response now so later writes cannot reach it.
  always_comb begin
    w_data_p0 = '0;
    w_miss_p0 = 1'b0;
    if (w_vld_p0 && !w_rd_oob) begin
      if (w_fwd)
        w_data_p0 = bus.wr_data;
      else if (r_written[bus.fibre_a_addr])
        w_data_p0 = r_mem[bus.fibre_a_addr];
      else
        w_miss_p0 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok)
      r_mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_written <= '0;
    else if (w_wr_ok)
      r_written[bus.wr_addr] <= 1'b1;
  end

  // Delay stages 1..READ_LATENCY; the last one is the output register and holds its data.
  for (genvar k = 1; k <= READ_LATENCY; k++) begin : g_stage
    logic                 w_vld_in;
    logic [TIMESTEPS-1:0] w_data_in;
    logic                 r_vld;
    logic [TIMESTEPS-1:0] r_data;

    if (k == 1) begin : g_first
      assign w_vld_in  = w_vld_p0;
      assign w_data_in = w_data_p0;
    end else begin : g_next
      assign w_vld_in  = g_stage[k-1].r_vld;
      assign w_data_in = g_stage[k-1].r_data;
    end

    always_ff @(posedge clk) begin
      if (rst)
        r_vld <= 1'b0;
      else
        r_vld <= w_vld_in;
    end

    if (k == READ_LATENCY) begin : g_out
      always_ff @(posedge clk) begin
        if (rst)
          r_data <= '0;
        else if (w_vld_in)
          r_data <= w_data_in;
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        r_data <= w_data_in;
      end
    end
  end

  assign w_out_vld = g_stage[READ_LATENCY].r_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_miss   <= 1'b0;
      r_oob    <= 1'b0;
      r_served <= '0;
    end else begin
      if (w_miss_p0)
        r_miss <= 1'b1;
      if (w_rd_oob || w_wr_oob)
        r_oob <= 1'b1;
      if (w_out_vld && (r_served != 16'hFFFF))
        r_served <= r_served + 16'd1;
    end
  end

  assign bus.fibre_a_data  = g_stage[READ_LATENCY].r_data;
  assign bus.fibre_a_valid = w_out_vld;
  assign bus.rd_miss       = r_miss;
  assign bus.rd_oob        = r_oob;
  assign bus.reads_served  = r_served;
endmodule

// File: tb/tb_fibre_a_responder.sv
// Directed and randomized bench for fibre_a_responder against a queue-based response model.
module tb_fibre_a_responder;
  localparam int TS    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 200;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fibre_a_responder_if #(.TIMESTEPS(TS), .ADDR_WIDTH(AW)) bus ();

  fibre_a_responder #(
    .TIMESTEPS(TS), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int            due;
    logic [TS-1:0] data;
  } resp_t;

  logic [TS-1:0] m_mem  [256];
  bit            m_flag [256];
  resp_t         m_q [$];
  int            cyc = 0;
  bit            m_vld = 0;
  logic [TS-1:0] m_data = '0;
  bit            m_miss = 0;
  bit            m_oob = 0;
  int            m_served = 0;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock: drive inputs, advance the model by the spec rules, compare all outputs.
  task automatic step(input bit r, input bit we, input int wa, input logic [TS-1:0] wd,
                      input bit re, input int ra);
    logic [TS-1:0] d;
    rst                 = r;
    bus.wr_en           = we;
    bus.wr_addr         = wa[AW-1:0];
    bus.wr_data         = wd;
    bus.fibre_a_read_en = re;
    bus.fibre_a_addr    = ra[AW-1:0];
    @(posedge clk);
    cyc++;
    if (r) begin
      for (int i = 0; i < 256; i++) m_flag[i] = 0;
      m_q.delete();
      m_vld = 0; m_data = '0; m_miss = 0; m_oob = 0; m_served = 0;
    end else begin
      if (m_vld && m_served < 65535) m_served++;
      if (re) begin
        d = '0;
        if (ra >= DEPTH) m_oob = 1;
        else if (we && wa == ra) d = wd;
        else if (m_flag[ra]) d = m_mem[ra];
        else m_miss = 1;
        m_q.push_back('{due: cyc + LAT - 1, data: d});
      end
      if (we) begin
        if (wa < DEPTH) begin
          m_mem[wa]  = wd;
          m_flag[wa] = 1;
        end else m_oob = 1;
      end
      m_vld = 0;
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        m_vld  = 1;
        m_data = m_q[0].data;
        void'(m_q.pop_front());
      end
    end
    #1;
    chk("valid",   32'(bus.fibre_a_valid), 32'(m_vld));
    chk("data",    32'(bus.fibre_a_data),  32'(m_data));
    chk("rd_miss", 32'(bus.rd_miss),       32'(m_miss));
    chk("rd_oob",  32'(bus.rd_oob),        32'(m_oob));
    chk("served",  32'(bus.reads_served),  32'(m_served));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.fibre_a_read_en = 1'b0; bus.fibre_a_addr = '0;

    // Reset, with requests that must be ignored while rst is high
    step(1, 0, 0, '0, 0, 0);
    step(1, 1, 7, 8'h5A, 1, 7);
    step(1, 0, 0, '0, 0, 0);

    // Single write then read of addr 3
    step(0, 1, 3, 8'hA5, 0, 0);
    idle(1);
    step(0, 0, 0, '0, 1, 3);
    idle(3);

    // Back-to-back reads of four entries
    for (int i = 0; i < 4; i++) step(0, 1, i, 8'(8'h11 * (i + 1)), 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, i);
    idle(3);

    // Same-cycle forwarding, then a later write that must not reach the in-flight response
    step(0, 1, 9, 8'h7E, 1, 9);
    step(0, 1, 9, 8'h01, 0, 0);
    idle(2);
    step(0, 0, 0, '0, 1, 9);
    idle(3);

    // Out-of-range read and write
    step(0, 0, 0, '0, 1, 250);
    step(0, 1, 210, 8'hFF, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 1, i);
    idle(3);

    // Read of an unwritten entry after reset
    step(1, 0, 0, '0, 0, 0);
    step(0, 0, 0, '0, 1, 5);
    idle(4);

    // Reset landing on in-flight reads
    step(1, 0, 0, '0, 0, 0);
    step(0, 1, 3, 8'h3C, 0, 0);
    step(0, 0, 0, '0, 1, 3);
    step(1, 0, 0, '0, 1, 3);
    idle(4);
    step(0, 0, 0, '0, 1, 3);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      automatic bit r  = ($urandom_range(0, 63) == 0);
      automatic bit we = ($urandom_range(0, 1) == 1);
      automatic int wa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 255))
                                                     : int'($urandom_range(0, 15));
      automatic bit re = ($urandom_range(0, 3) != 0);
      automatic int ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(200, 255))
                                                     : int'($urandom_range(0, 15));
      step(r, we, wa, 8'($urandom), re, ra);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
